// File: rtl/oscillo_trig_capture.sv
// Triggered single-clock capture engine: circular sample RAM, level or forced trigger with
// pretrigger history, then time-ordered readout of the record over a valid/ready stream.
module oscillo_trig_capture #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 9,
  parameter int PRETRIG = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              mode_auto,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_fall,
  input  logic              force_trig,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        state,
  output logic              triggered
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   PRE_LAST  = (ADDR_W+1)'(PRETRIG - 1);
  localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W+1)'(DEPTH - PRETRIG - 1);
  localparam logic [ADDR_W:0]   REC_LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   POST_INIT = (ADDR_W+1)'((DEPTH - PRETRIG == 1) ? 0 : 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
  localparam bit                NO_PRE    = (PRETRIG == 0);
  localparam bit                NO_POST   = (DEPTH - PRETRIG == 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_READ = 3'd4
  } state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]     r_cnt, r_issue_cnt;
  logic [DATA_W-1:0]   r_prev, r_ram_q, r_out_data;
  logic                r_prev_ok, r_q_vld, r_out_valid, r_triggered;

  logic w_intake, w_cross, w_trig, w_pre_done, w_post_done;
  logic w_issue, w_done, w_start, w_xfer, w_a_en, w_b_en;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (arm)         w_next = S_PRE;
      S_PRE:  if (w_pre_done)  w_next = S_WAIT;
      S_WAIT: if (w_trig)      w_next = NO_POST ? S_READ : S_POST;
      S_POST: if (w_post_done) w_next = S_READ;
      S_READ: if (w_done)      w_next = mode_auto ? S_PRE : S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default up front so no path leaves it unassigned (no latch).
  always_comb begin
    w_intake    = 1'b0;
    w_trig      = 1'b0;
    w_pre_done  = 1'b0;
    w_post_done = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_start     = 1'b0;
    w_cross     = trig_fall ? (r_prev >= trig_level && sample_data <  trig_level)
                            : (r_prev <  trig_level && sample_data >= trig_level);
    w_xfer      = r_out_valid && out_ready;
    // Two-stage read pipeline (RAM register, output register) advances as one stall-coupled chain.
    w_b_en      = !r_out_valid || out_ready;
    w_a_en      = !r_q_vld || w_b_en;
    case (r_state)
      S_IDLE: w_start = arm;
      S_PRE: begin
        w_intake   = sample_valid && !NO_PRE;
        w_pre_done = NO_PRE || (sample_valid && r_cnt == PRE_LAST);
      end
      S_WAIT: begin
        w_intake = sample_valid;
        w_trig   = sample_valid && (force_trig || (r_prev_ok && w_cross));
      end
      S_POST: begin
        w_intake    = sample_valid;
        w_post_done = sample_valid && r_cnt == POST_LAST;
      end
      S_READ: begin
        w_issue = w_a_en && (r_issue_cnt != CNT_DEPTH);
        w_done  = w_xfer && r_cnt == REC_LAST;
        w_start = w_done && mode_auto;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_issue_cnt <= '0;
      r_prev      <= '0;
      r_prev_ok   <= 1'b0;
      r_q_vld     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_triggered <= 1'b0;
    end else begin
      if (w_intake) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_prev    <= sample_data;
        r_prev_ok <= 1'b1;
      end
      case (r_state)
        S_PRE: if (w_intake) r_cnt <= r_cnt + 1'b1;
        S_WAIT: if (w_trig) begin
          // The trigger sample lands at r_wr_ptr, so the record starts PRETRIG slots earlier.
          r_cnt       <= POST_INIT;
          r_rd_ptr    <= r_wr_ptr - PRE_OFS;
          r_issue_cnt <= '0;
          r_triggered <= 1'b1;
        end
        S_POST: begin
          if (w_post_done)   r_cnt <= '0;
          else if (w_intake) r_cnt <= r_cnt + 1'b1;
        end
        S_READ: begin
          if (w_issue) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
          if (w_xfer) r_cnt <= r_cnt + 1'b1;
          if (w_b_en) begin
            r_out_valid <= r_q_vld;
            if (r_q_vld) r_out_data <= r_ram_q;
          end
          if (w_a_en) r_q_vld <= w_issue;
          if (w_done) begin
            r_cnt       <= '0;
            r_triggered <= 1'b0;
            r_out_valid <= 1'b0;
            r_q_vld     <= 1'b0;
          end
        end
        default: ;
      endcase
      if (w_start) begin
        r_wr_ptr  <= '0;
        r_cnt     <= '0;
        r_prev_ok <= 1'b0;
      end
    end
  end

  // NOTE: the sample RAM and its read register carry no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_intake) r_mem[r_wr_ptr] <= sample_data;
    if (w_issue)  r_ram_q <= r_mem[r_rd_ptr];
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign state     = r_state;
  assign triggered = r_triggered;

endmodule

// File: tb/tb_oscillo_trig_capture.sv
// Bench for oscillo_trig_capture (DEPTH 16, PRETRIG 4): table of capture scenarios plus
// auto-rearm and mid-capture reset sequences, with a scoreboard queue of expected record bytes.
module tb_oscillo_trig_capture;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int PRETRIG = 4;
  localparam int DEPTH   = 16;

  logic              clk, rst_n, arm, mode_auto, trig_fall, force_trig;
  logic              sample_valid, out_valid, out_ready, triggered;
  logic [DATA_W-1:0] trig_level, sample_data, out_data;
  logic [2:0]        state;

  oscillo_trig_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRETRIG(PRETRIG)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .mode_auto(mode_auto),
    .trig_level(trig_level), .trig_fall(trig_fall), .force_trig(force_trig),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .state(state), .triggered(triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {P_RAMP, P_STEP, P_SINE} pat_t;

  typedef struct {
    pat_t       pat;
    int         base;
    logic [7:0] level;
    logic       fall;
    int         force_at;
    int         ready_pct;
    logic [7:0] exp_first;
    logic [7:0] exp_trig;
  } vec_t;

  logic [7:0] exp_q[$];
  logic [7:0] got[DEPTH];
  int total, bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sample_at(input pat_t p, input int base, input int i);
    int ph;
    case (p)
      P_RAMP: return 8'((base + i) & 255);
      P_STEP: return (i < 44) ? 8'h00 : 8'h80;
      default: begin
        ph = i % 32;
        return (ph < 16) ? 8'(255 - 17 * ph) : 8'(17 * (ph - 16));
      end
    endcase
  endfunction

  // Reference trigger search: samples 0..PRETRIG-1 are pretrigger history and never trigger.
  function automatic int trig_index(input vec_t v);
    logic [7:0] cur, prv;
    for (int i = PRETRIG; i < 256; i++) begin
      cur = sample_at(v.pat, v.base, i);
      prv = sample_at(v.pat, v.base, i - 1);
      if (i == v.force_at) return i;
      if (v.fall ? (prv >= v.level && cur < v.level) : (prv < v.level && cur >= v.level)) return i;
    end
    return -1;
  endfunction

  task automatic feed(input pat_t p, input int base, input int n, input int force_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = sample_at(p, base, i);
      force_trig   = (i == force_at);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    force_trig   = 1'b0;
  endtask

  task automatic collect(input int ready_pct, input logic [2:0] end_state);
    int n, cyc;
    logic stalled, seen;
    logic [7:0] held, exp_val;
    n = 0; cyc = 0; stalled = 1'b0; seen = 1'b0; held = '0;
    while (n < DEPTH && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held);
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid) begin
        if (!seen) check("triggered_in_read", triggered, 1);
        seen = 1'b1;
        if (out_ready) begin
          exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check("data", out_data, exp_val);
          got[n] = out_data;
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end else begin
        stalled = 1'b0;
      end
    end
    check("xfer_count", n, DEPTH);
    @(negedge clk);
    check("done_valid", out_valid, 0);
    check("done_triggered", triggered, 0);
    check("done_state", state, end_state);
    out_ready = 1'b0;
  endtask

  task automatic run_capture(input vec_t v, input int n, input bit do_arm, input logic [2:0] end_state);
    int t;
    t = trig_index(v);
    if (t >= 0)
      for (int k = 0; k < DEPTH; k++) exp_q.push_back(sample_at(v.pat, v.base, t - PRETRIG + k));
    trig_level = v.level;
    trig_fall  = v.fall;
    if (do_arm) begin
      @(negedge clk); arm = 1'b1;
      @(negedge clk); arm = 1'b0;
    end
    fork
      feed(v.pat, v.base, n, v.force_at);
      collect(v.ready_pct, end_state);
    join
    check("sb_empty", exp_q.size(), 0);
    check("rec_first", got[0], v.exp_first);
    check("rec_trig", got[PRETRIG], v.exp_trig);
  endtask

  vec_t vecs[5];

  initial begin
    total = 0; bad = 0;
    arm = 0; mode_auto = 0; trig_level = '0; trig_fall = 0; force_trig = 0;
    sample_valid = 0; sample_data = '0; out_ready = 0;

    vecs[0] = '{P_RAMP, 0, 8'd20,  1'b0, -1, 100, 8'd16,  8'd20};
    vecs[1] = '{P_RAMP, 0, 8'd2,   1'b0, 10, 100, 8'd6,   8'd10};
    vecs[2] = '{P_STEP, 0, 8'h40,  1'b0, -1, 100, 8'h00,  8'h80};
    vecs[3] = '{P_SINE, 0, 8'h80,  1'b1, -1, 50,  8'hBB,  8'h77};
    vecs[4] = '{P_RAMP, 0, 8'd20,  1'b0, -1, 30,  8'd16,  8'd20};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_triggered", triggered, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_capture(vecs[i], 64, 1'b1, 3'd0);

    // Auto-rearm: second record is captured without a new arm pulse.
    mode_auto = 1'b1;
    run_capture('{P_RAMP, 0,   8'd20,  1'b0, -1, 100, 8'd16,  8'd20},  32, 1'b1, 3'd1);
    run_capture('{P_RAMP, 100, 8'd120, 1'b0, -1, 70,  8'd116, 8'd120}, 32, 1'b0, 3'd1);

    // Asynchronous reset while in POST.
    trig_level = 8'd120;
    trig_fall  = 1'b0;
    feed(P_RAMP, 100, 25, -1);
    check("post_state", state, 3);
    check("post_triggered", triggered, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_triggered", triggered, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
